// File: rtl/irq_entry_sequencer.sv
// Interrupt/reset entry sequencer for the BrainForge8 core: push return PC, fetch vector, load PC, ACK.
// Optional IRQ_SEQ_LATCNT_EN adds lat_last_o, the acceptance-to-ACK latency of the last entry.
module irq_entry_sequencer #(
    parameter int unsigned PC_W     = 16,
    parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            next_on_i,
    input  logic [3:0]      next_id_i,
    input  logic            reset_on_i,
    output logic            ack_o,
    input  logic            ie_i,
    input  logic            boundary_i,
    input  logic [PC_W-1:0] pc_in_i,
    output logic            stall_o,
    output logic            ie_clr_o,
    output logic            stk_push_o,
    output logic [7:0]      stk_data_o,
    input  logic            stk_full_i,
    output logic            trig_stof_o,
    output logic            vec_rd_o,
    output logic [15:0]     vec_addr_o,
    input  logic [7:0]      vec_data_i,
    input  logic            vec_rdy_i,
    output logic            pc_load_o,
    output logic [PC_W-1:0] pc_out_o
`ifdef IRQ_SEQ_LATCNT_EN
    ,
    output logic [7:0]      lat_last_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        VEC_LO,
        VEC_HI,
        LOAD,
        ACKS
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      id_q, id_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      vec_lo_q, vec_lo_d;
    logic [7:0]      vec_hi_q, vec_hi_d;
    logic            stall_q;
    logic            ie_clr_q, ie_clr_d;
    logic            reset_on_q;

    logic            irq_ok;
    logic            reset_rise;
    logic            abandon;
    logic [15:0]     pc_ext;
    logic [15:0]     vec_word;
    logic [15:0]     vec_base_addr;

    assign irq_ok        = next_on_i & ie_i & boundary_i;
    assign reset_rise    = reset_on_i & ~reset_on_q;
    assign pc_ext        = 16'(pc_q);
    assign vec_word      = {vec_hi_q, vec_lo_q};
    assign vec_base_addr = VEC_BASE + {11'b0, id_q, 1'b0};

    // A fresh reset request preempts an entry until the PC has been committed in LOAD.
    assign abandon = reset_rise &&
                     (state_q == PUSH_HI || state_q == PUSH_LO ||
                      state_q == VEC_LO  || state_q == VEC_HI);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            id_q       <= '0;
            pc_q       <= '0;
            vec_lo_q   <= '0;
            vec_hi_q   <= '0;
            stall_q    <= 1'b0;
            ie_clr_q   <= 1'b0;
            reset_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            pc_q       <= pc_d;
            vec_lo_q   <= vec_lo_d;
            vec_hi_q   <= vec_hi_d;
            stall_q    <= (state_d != IDLE);
            ie_clr_q   <= ie_clr_d;
            reset_on_q <= reset_on_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        pc_d        = pc_q;
        vec_lo_d    = vec_lo_q;
        vec_hi_d    = vec_hi_q;
        ie_clr_d    = 1'b0;
        stk_push_o  = 1'b0;
        stk_data_o  = 8'h00;
        trig_stof_o = 1'b0;
        vec_rd_o    = 1'b0;
        vec_addr_o  = 16'h0000;
        pc_load_o   = 1'b0;
        pc_out_o    = '0;
        ack_o       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (reset_on_i) begin
                    id_d    = 4'd0;
                    pc_d    = pc_in_i;
                    state_d = VEC_LO;
                end else if (irq_ok) begin
                    id_d     = next_id_i;
                    pc_d     = pc_in_i;
                    ie_clr_d = 1'b1;
                    state_d  = PUSH_HI;
                end
            end
            PUSH_HI, PUSH_LO: begin
                if (abandon) begin
                    id_d    = 4'd0;
                    state_d = VEC_LO;
                end else if (stk_full_i) begin
                    // Overflow loses the return address but the entry still completes.
                    trig_stof_o = 1'b1;
                    state_d     = VEC_LO;
                end else begin
                    stk_push_o = 1'b1;
                    stk_data_o = (state_q == PUSH_HI) ? pc_ext[15:8] : pc_ext[7:0];
                    state_d    = (state_q == PUSH_HI) ? PUSH_LO : VEC_LO;
                end
            end
            VEC_LO: begin
                vec_rd_o   = 1'b1;
                vec_addr_o = vec_base_addr;
                if (abandon) begin
                    id_d = 4'd0;
                end else if (vec_rdy_i) begin
                    vec_lo_d = vec_data_i;
                    state_d  = VEC_HI;
                end
            end
            VEC_HI: begin
                vec_rd_o   = 1'b1;
                vec_addr_o = vec_base_addr + 16'd1;
                if (abandon) begin
                    id_d    = 4'd0;
                    state_d = VEC_LO;
                end else if (vec_rdy_i) begin
                    vec_hi_d = vec_data_i;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                pc_load_o = 1'b1;
                pc_out_o  = vec_word[PC_W-1:0];
                state_d   = ACKS;
            end
            ACKS: begin
                ack_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_o  = stall_q;
    assign ie_clr_o = ie_clr_q;

`ifdef IRQ_SEQ_LATCNT_EN
    logic [7:0] lat_cnt_q;
    logic [7:0] lat_last_q;

    // Counter holds the number of edges since acceptance; sampled into lat_last on the ACK edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_cnt_q  <= 8'h00;
            lat_last_q <= 8'h00;
        end else begin
            if (state_q == IDLE) begin
                lat_cnt_q <= (state_d != IDLE) ? 8'd1 : 8'd0;
            end else if (lat_cnt_q != 8'hFF) begin
                lat_cnt_q <= lat_cnt_q + 8'd1;
            end
            if (state_q == ACKS) begin
                lat_last_q <= lat_cnt_q;
            end
        end
    end

    assign lat_last_o = lat_last_q;
`endif

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Directed bench for irq_entry_sequencer: a vector table for the basic entries plus
// hand-written sequences for gating, stack overflow, ROM wait states and reset preemption.
module tb_irq_entry_sequencer;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nextOn;
    logic [3:0]  nextId;
    logic        resetOn;
    logic        ack;
    logic        ie;
    logic        boundary;
    logic [15:0] pcIn;
    logic        stall;
    logic        ieClr;
    logic        stkPush;
    logic [7:0]  stkData;
    logic        stkFull;
    logic        trigStof;
    logic        vecRd;
    logic [15:0] vecAddr;
    logic [7:0]  vecData;
    logic        vecRdy;
    logic        pcLoad;
    logic [15:0] pcOut;
`ifdef IRQ_SEQ_LATCNT_EN
    logic [7:0]  latLast;
`endif

    int total = 0;
    int bad   = 0;

    // One row = inputs driven for one cycle, then the outputs expected in that cycle.
    typedef struct {
        logic        rstOn;
        logic        nextOn;
        logic [3:0]  id;
        logic        ie;
        logic        bnd;
        logic [15:0] pcIn;
        logic        full;
        logic        rdy;
        logic [7:0]  vdata;
        logic        stall;
        logic        ieClr;
        logic        push;
        logic [7:0]  sdata;
        logic        stof;
        logic        vrd;
        logic [15:0] vaddr;
        logic        pload;
        logic [15:0] pcOut;
        logic        ack;
    } vec_t;

    vec_t tbl[$];

    irq_entry_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .next_on_i   (nextOn),
        .next_id_i   (nextId),
        .reset_on_i  (resetOn),
        .ack_o       (ack),
        .ie_i        (ie),
        .boundary_i  (boundary),
        .pc_in_i     (pcIn),
        .stall_o     (stall),
        .ie_clr_o    (ieClr),
        .stk_push_o  (stkPush),
        .stk_data_o  (stkData),
        .stk_full_i  (stkFull),
        .trig_stof_o (trigStof),
        .vec_rd_o    (vecRd),
        .vec_addr_o  (vecAddr),
        .vec_data_i  (vecData),
        .vec_rdy_i   (vecRdy),
        .pc_load_o   (pcLoad),
        .pc_out_o    (pcOut)
`ifdef IRQ_SEQ_LATCNT_EN
        ,
        .lat_last_o  (latLast)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
    task automatic drive(input logic r, input logic n, input logic [3:0] id, input logic e,
                         input logic b, input logic [15:0] pc, input logic f, input logic rd,
                         input logic [7:0] d);
        @(negedge clk);
        resetOn  = r;
        nextOn   = n;
        nextId   = id;
        ie       = e;
        boundary = b;
        pcIn     = pc;
        stkFull  = f;
        vecRdy   = rd;
        vecData  = d;
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.rstOn, v.nextOn, v.id, v.ie, v.bnd, v.pcIn, v.full, v.rdy, v.vdata);
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkVal({tag, ".stall"}, 16'(stall),    16'(v.stall));
        checkVal({tag, ".ieclr"}, 16'(ieClr),    16'(v.ieClr));
        checkVal({tag, ".push"},  16'(stkPush),  16'(v.push));
        checkVal({tag, ".sdata"}, 16'(stkData),  16'(v.sdata));
        checkVal({tag, ".stof"},  16'(trigStof), 16'(v.stof));
        checkVal({tag, ".vrd"},   16'(vecRd),    16'(v.vrd));
        checkVal({tag, ".vaddr"}, vecAddr,       v.vaddr);
        checkVal({tag, ".pload"}, 16'(pcLoad),   16'(v.pload));
        checkVal({tag, ".pcout"}, pcOut,         v.pcOut);
        checkVal({tag, ".ack"},   16'(ack),      16'(v.ack));
    endtask

    initial begin
        vec_t        zeroRow;
        logic        rdyK;
        logic [7:0]  datK;
        logic [7:0]  expSdata;
        logic [15:0] expAddr;

        zeroRow = '{N,N,4'd0,N,N,16'h0000,N,N,8'h00, N,N,N,8'h00,N,N,16'h0000,N,16'h0000,N};

        // Reset entry from IDLE: vector 0 = 1234h, no push, ACK four edges after acceptance.
        tbl.push_back('{Y,N,4'd0,N,N,16'h0000,N,N,8'h00, N,N,N,8'h00,N,N,16'h0000,N,16'h0000,N});
        tbl.push_back('{Y,N,4'd0,N,N,16'h0000,N,Y,8'h34, Y,N,N,8'h00,N,Y,16'hFFE0,N,16'h0000,N});
        tbl.push_back('{Y,N,4'd0,N,N,16'h0000,N,Y,8'h12, Y,N,N,8'h00,N,Y,16'hFFE1,N,16'h0000,N});
        tbl.push_back('{Y,N,4'd0,N,N,16'h0000,N,N,8'h00, Y,N,N,8'h00,N,N,16'h0000,Y,16'h1234,N});
        tbl.push_back('{N,N,4'd0,N,N,16'h0000,N,N,8'h00, Y,N,N,8'h00,N,N,16'h0000,N,16'h0000,Y});
        tbl.push_back('{N,N,4'd0,N,N,16'h0000,N,N,8'h00, N,N,N,8'h00,N,N,16'h0000,N,16'h0000,N});
        // Interrupt ID 3 from PC 0ABCh; stray VEC_RDY in IDLE and an ID change mid-entry are ignored.
        tbl.push_back('{N,Y,4'd3,Y,Y,16'h0ABC,N,Y,8'hFF, N,N,N,8'h00,N,N,16'h0000,N,16'h0000,N});
        tbl.push_back('{N,Y,4'd7,N,Y,16'h0000,N,N,8'h00, Y,Y,Y,8'h0A,N,N,16'h0000,N,16'h0000,N});
        tbl.push_back('{N,Y,4'd7,N,Y,16'h0000,N,N,8'h00, Y,N,Y,8'hBC,N,N,16'h0000,N,16'h0000,N});
        tbl.push_back('{N,Y,4'd3,N,Y,16'h0000,N,Y,8'hCD, Y,N,N,8'h00,N,Y,16'hFFE6,N,16'h0000,N});
        tbl.push_back('{N,Y,4'd3,N,Y,16'h0000,N,Y,8'hAB, Y,N,N,8'h00,N,Y,16'hFFE7,N,16'h0000,N});
        tbl.push_back('{N,Y,4'd3,N,Y,16'h0000,N,N,8'h00, Y,N,N,8'h00,N,N,16'h0000,Y,16'hABCD,N});
        tbl.push_back('{N,N,4'd0,N,N,16'h0000,N,N,8'h00, Y,N,N,8'h00,N,N,16'h0000,N,16'h0000,Y});
        tbl.push_back('{N,N,4'd0,N,N,16'h0000,N,N,8'h00, N,N,N,8'h00,N,N,16'h0000,N,16'h0000,N});

        rst_n = 1'b0;
        resetOn = 1'b0; nextOn = 1'b0; nextId = 4'd0; ie = 1'b0; boundary = 1'b0;
        pcIn = 16'h0000; stkFull = 1'b0; vecRdy = 1'b0; vecData = 8'h00;
        #1;
        checkOutput(zeroRow, "reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("row%0d", i));
        end

        // Gated by IE and BOUNDARY, then a stack overflow on the high-byte push.
        drive(N,Y,4'd1,N,Y,16'h0100,N,N,8'h00); checkVal("t3.ie0.stall", 16'(stall), 16'd0);
        drive(N,Y,4'd1,N,Y,16'h0100,N,N,8'h00); checkVal("t3.ie0.push", 16'(stkPush), 16'd0);
        drive(N,Y,4'd1,Y,N,16'h0100,N,N,8'h00); checkVal("t3.bnd0.stall", 16'(stall), 16'd0);
        drive(N,Y,4'd1,Y,Y,16'h0100,N,N,8'h00); checkVal("t3.accept.stall", 16'(stall), 16'd0);
        drive(N,Y,4'd1,N,Y,16'h0100,Y,N,8'h00);
        checkVal("t4.stall", 16'(stall), 16'd1);
        checkVal("t4.ieclr", 16'(ieClr), 16'd1);
        checkVal("t4.nopush", 16'(stkPush), 16'd0);
        checkVal("t4.stof", 16'(trigStof), 16'd1);
        drive(N,Y,4'd1,N,Y,16'h0100,Y,Y,8'h78);
        checkVal("t4.stof_once", 16'(trigStof), 16'd0);
        checkVal("t4.nopush2", 16'(stkPush), 16'd0);
        checkVal("t4.vaddr_lo", vecAddr, 16'hFFE2);
        drive(N,Y,4'd1,N,Y,16'h0100,N,Y,8'h56); checkVal("t4.vaddr_hi", vecAddr, 16'hFFE3);
        drive(N,Y,4'd1,N,Y,16'h0100,N,N,8'h00); checkVal("t4.pcout", pcOut, 16'h5678);
        drive(N,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t4.ack", 16'(ack), 16'd1);
        drive(N,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t4.idle", 16'(stall), 16'd0);

        // Three wait cycles per vector byte push ACK from edge N+6 to N+12.
        drive(N,Y,4'd2,Y,Y,16'h00FF,N,N,8'h00); checkVal("t5.accept.stall", 16'(stall), 16'd0);
        for (int k = 1; k <= 13; k++) begin
            rdyK = (k == 6) || (k == 10);
            datK = (k == 6) ? 8'h11 : ((k == 10) ? 8'h22 : 8'h00);
            drive(N, (k < 12), 4'd2, N, Y, 16'h0000, N, rdyK, datK);
            expSdata = (k == 1) ? 8'h00 : ((k == 2) ? 8'hFF : 8'h00);
            expAddr  = (k >= 3 && k <= 6) ? 16'hFFE4 : ((k >= 7 && k <= 10) ? 16'hFFE5 : 16'h0000);
            checkVal($sformatf("t5.k%0d.stall", k), 16'(stall), 16'(k <= 12));
            checkVal($sformatf("t5.k%0d.push", k), 16'(stkPush), 16'(k == 1 || k == 2));
            checkVal($sformatf("t5.k%0d.sdata", k), 16'(stkData), 16'(expSdata));
            checkVal($sformatf("t5.k%0d.vrd", k), 16'(vecRd), 16'(k >= 3 && k <= 10));
            checkVal($sformatf("t5.k%0d.vaddr", k), vecAddr, expAddr);
            checkVal($sformatf("t5.k%0d.pload", k), 16'(pcLoad), 16'(k == 11));
            checkVal($sformatf("t5.k%0d.pcout", k), pcOut, (k == 11) ? 16'h2211 : 16'h0000);
            checkVal($sformatf("t5.k%0d.ack", k), 16'(ack), 16'(k == 12));
        end
`ifdef IRQ_SEQ_LATCNT_EN
        checkVal("t5.latency", 16'(latLast), 16'd12);
`endif

        // RESET_ON rising in PUSH_LO abandons interrupt 5 and takes the reset vector.
        drive(N,Y,4'd5,Y,Y,16'h1357,N,N,8'h00); checkVal("t6.accept.stall", 16'(stall), 16'd0);
        drive(N,Y,4'd5,N,Y,16'h0000,N,N,8'h00); checkVal("t6.push_hi", 16'(stkData), 16'h0013);
        drive(Y,Y,4'd5,N,Y,16'h0000,N,N,8'h00);
        checkVal("t6.abandon.nopush", 16'(stkPush), 16'd0);
        checkVal("t6.abandon.stall", 16'(stall), 16'd1);
        drive(Y,N,4'd5,N,Y,16'h0000,N,Y,8'h00);
        checkVal("t6.vaddr_lo", vecAddr, 16'hFFE0);
        checkVal("t6.nopush", 16'(stkPush), 16'd0);
        drive(Y,N,4'd5,N,Y,16'h0000,N,Y,8'hF0); checkVal("t6.vaddr_hi", vecAddr, 16'hFFE1);
        drive(Y,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t6.pcout", pcOut, 16'hF000);
        drive(N,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t6.ack", 16'(ack), 16'd1);
        drive(N,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t6.idle", 16'(stall), 16'd0);

        // RESET_ON arriving in LOAD lets the interrupt finish, then enters reset from IDLE.
        drive(N,Y,4'd4,Y,Y,16'h0000,N,N,8'h00);
        drive(N,N,4'd4,N,Y,16'h0000,N,N,8'h00);
        drive(N,N,4'd4,N,Y,16'h0000,N,N,8'h00);
        drive(N,N,4'd4,N,Y,16'h0000,N,Y,8'h01); checkVal("t7.vaddr_lo", vecAddr, 16'hFFE8);
        drive(N,N,4'd4,N,Y,16'h0000,N,Y,8'h02); checkVal("t7.vaddr_hi", vecAddr, 16'hFFE9);
        drive(Y,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t7.pcout", pcOut, 16'h0201);
        drive(Y,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t7.ack", 16'(ack), 16'd1);
        drive(Y,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t7.idle", 16'(stall), 16'd0);
        drive(Y,N,4'd0,N,N,16'h0000,N,Y,8'hAA);
        checkVal("t7.reset.vaddr", vecAddr, 16'hFFE0);
        checkVal("t7.reset.nopush", 16'(stkPush), 16'd0);
        checkVal("t7.reset.noieclr", 16'(ieClr), 16'd0);
        drive(Y,N,4'd0,N,N,16'h0000,N,Y,8'h55);
        drive(Y,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t7.reset.pcout", pcOut, 16'h55AA);
        drive(N,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t7.reset.ack", 16'(ack), 16'd1);
`ifdef IRQ_SEQ_LATCNT_EN
        drive(N,N,4'd0,N,N,16'h0000,N,N,8'h00); checkVal("t7.latency", 16'(latLast), 16'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
